// File: rtl/positional.sv
// Registered three-pair AND-OR function of x1..x6 with a two-edge input-to-output latency.
// Optional stability filter on OUT is compiled in by defining POSITIONAL_FILTER_EN.
module positional #(
  parameter int FILTER_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic x6,
  output logic OUT
);

  logic xr1, xr2, xr3, xr4, xr5, xr6;
  logic f;

  if ((FILTER_LEN < 1) || (FILTER_LEN > 15)) begin : g_bad_filter_len
    $error("positional: FILTER_LEN must be in 1..15");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {xr1, xr2, xr3, xr4, xr5, xr6} <= 6'b000000;
    end else begin
      {xr1, xr2, xr3, xr4, xr5, xr6} <= {x1, x2, x3, x4, x5, x6};
    end
  end

  assign f = (xr1 & xr2) | (xr3 & xr4) | (xr5 & xr6);

`ifdef POSITIONAL_FILTER_EN
  localparam logic [3:0] LEN = 4'(FILTER_LEN);

  logic [3:0] cnt;
  logic       cand;

  // cnt counts edges at which f matched a candidate differing from OUT; OUT
  // commits one edge after the count reaches LEN, giving 2+LEN edges latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      OUT  <= 1'b0;
      cnt  <= 4'd0;
      cand <= 1'b0;
    end else if (cnt == LEN) begin
      OUT <= cand;
      cnt <= 4'd0;
    end else if (f == OUT) begin
      cnt <= 4'd0;
    end else if ((cnt != 4'd0) && (f == cand)) begin
      cnt <= cnt + 4'd1;
    end else begin
      cand <= f;
      cnt  <= 4'd1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      OUT <= 1'b0;
    end else begin
      OUT <= f;
    end
  end
`endif

endmodule

// File: tb/tb_positional.sv
// Directed self-checking bench for positional: reset, vectors, exhaustive sweep,
// mid-operation reset, async-pulse immunity and (when compiled in) the filter.
module tb_positional;

  localparam int FL = 2;
`ifdef POSITIONAL_FILTER_EN
  localparam int LAT = 2 + FL;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x1 = 1'b0, x2 = 1'b0, x3 = 1'b0, x4 = 1'b0, x5 = 1'b0, x6 = 1'b0;
  logic OUT;

  int checks = 0;
  int failures = 0;

  positional #(.FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6),
    .OUT(OUT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input logic [5:0] v);
    {x1, x2, x3, x4, x5, x6} = v;
  endtask

  function automatic logic model(input logic [5:0] v);
    return (v[5] & v[4]) | (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  task automatic test_reset();
    set_x(6'b111111);
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (OUT !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: OUT=%b expected 0", OUT);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      checks++;
      if (OUT !== (i == LAT)) begin
        failures++;
        $display("FAIL reset_release edge%0d: OUT=%b expected %b", i, OUT, (i == LAT));
      end
    end
  endtask

  task automatic test_vectors();
    logic [5:0] vecs [4] = '{6'b100100, 6'b001100, 6'b100000, 6'b100001};
    logic       exp  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      set_x(vecs[k]);
      for (int i = 1; i <= 5 + LAT - 2; i++) begin
        tick();
        if (i == LAT) begin
          checks++;
          if (OUT !== exp[k]) begin
            failures++;
            $display("FAIL vector %b: OUT=%b expected %b", vecs[k], OUT, exp[k]);
          end
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [5:0] v;
    logic       prev;
    set_x(6'b000000);
    repeat (LAT + 1) tick();
    prev = 1'b0;
    for (int n = 0; n < 64; n++) begin
      v = 6'(n);
      set_x(v);
      tick();
      checks++;
      if (OUT !== prev) begin
        failures++;
        $display("FAIL sweep_early %b: OUT=%b expected %b", v, OUT, prev);
      end
      for (int i = 2; i <= LAT; i++) tick();
      checks++;
      if (OUT !== model(v)) begin
        failures++;
        $display("FAIL sweep %b: OUT=%b expected %b", v, OUT, model(v));
      end
      tick();
      prev = model(v);
    end
  endtask

  task automatic test_pairs();
    logic [5:0] vecs [3] = '{6'b110000, 6'b001100, 6'b000011};
    for (int k = 0; k < 3; k++) begin
      set_x(6'b000000);
      repeat (LAT + 1) tick();
      set_x(vecs[k]);
      repeat (LAT) tick();
      checks++;
      if (OUT !== 1'b1) begin
        failures++;
        $display("FAIL pair %b: OUT=%b expected 1", vecs[k], OUT);
      end
    end
  endtask

  task automatic test_mid_reset();
    set_x(6'b000011);
    repeat (LAT + 1) tick();
    checks++;
    if (OUT !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: OUT=%b expected 1", OUT);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (OUT !== 1'b0) begin
      failures++;
      $display("FAIL midrst_edge: OUT=%b expected 0", OUT);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      checks++;
      if (OUT !== (i == LAT)) begin
        failures++;
        $display("FAIL midrst_release edge%0d: OUT=%b expected %b", i, OUT, (i == LAT));
      end
    end
  endtask

  task automatic test_async_pulse();
    set_x(6'b110000);
    repeat (LAT + 1) tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    checks++;
    if (OUT !== 1'b1) begin
      failures++;
      $display("FAIL async_pulse_immediate: OUT=%b expected 1", OUT);
    end
    tick();
    tick();
    checks++;
    if (OUT !== 1'b1) begin
      failures++;
      $display("FAIL async_pulse_after: OUT=%b expected 1", OUT);
    end
  endtask

`ifdef POSITIONAL_FILTER_EN
  task automatic test_filter();
    set_x(6'b000000);
    repeat (LAT + 2) tick();
    for (int i = 0; i < 12; i++) begin
      set_x({~x1, 5'b10000});
      tick();
      checks++;
      if (OUT !== 1'b0) begin
        failures++;
        $display("FAIL filter_toggle cyc%0d: OUT=%b expected 0", i, OUT);
      end
    end
    set_x(6'b000000);
    repeat (LAT + 2) tick();
    set_x(6'b110000);
    for (int i = 1; i <= LAT; i++) begin
      tick();
      checks++;
      if (OUT !== (i == LAT)) begin
        failures++;
        $display("FAIL filter_hold edge%0d: OUT=%b expected %b", i, OUT, (i == LAT));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_sweep();
    test_pairs();
    test_mid_reset();
    test_async_pulse();
`ifdef POSITIONAL_FILTER_EN
    test_filter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
